mult32x32_seq: RTL and testbench

Operand sequencer sitting directly upstream of the 32x32 multiplier (FSM + datapath). Accepts operand pairs over a valid/ready interface into a small FIFO and holds each pair stable on the multiplier operand inputs for a whole operation. Issues one-cycle start pulses, waits the fixed multiplier latency, then captures the 64-bit product into a valid/ready result register. Decouples producers and consumers from the multiplier's fixed 9-cycle run.

---
 rtl/mult32x32_seq.sv | 179 +++++++++++++++++
 tb/tb_mult32x32_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult32x32_seq.sv
// mult32x32_seq: operand sequencer in front of a fixed-latency 32x32 multiplier.
// Operand pairs are buffered in a small FIFO. Each pair is held stable on
// mult_a/mult_b for a whole run. The product is captured LAT cycles after the
// start pulse into a valid/ready result register.
//
// Parameters: DEPTH (FIFO entries, power of two 2..8), LAT (start-to-product cycles).
// Optional feature: define MULT_SEQ_CHECK_EN to enable the sticky mult_busy
// profile checker on err. Without the macro, err is tied to 0.
//
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   in_valid/in_ready/in_a/in_b   operand pair input (in_ready combinational)
//   mult_start/mult_a/mult_b      start pulse and operands to the multiplier
//   mult_busy/mult_product        multiplier status and product
//   out_valid/out_ready/out_product  captured result
//   err                           sticky busy-profile error
module mult32x32_seq #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned LAT   = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        mult_start,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic        mult_busy,
  input  logic [63:0] mult_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_product,
  output logic        err
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam int unsigned CW   = $clog2(LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_start, w_start_nxt;
  logic [31:0]     r_mult_a, r_mult_b;
  logic            r_out_valid;
  logic [63:0]     r_out_product;
  logic [31:0]     r_mem_a [DEPTH];
  logic [31:0]     r_mem_b [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic            w_push, w_pop, w_capture, w_slot_free;

  assign in_ready    = (r_count != CNTW'(DEPTH));
  assign w_push      = in_valid && in_ready;
  assign w_slot_free = !r_out_valid || out_ready;

  // Next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start_nxt = 1'b0;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_start_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CW'(LAT)) begin
          if (w_slot_free) begin
            w_capture   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_HOLD: begin
        if (w_slot_free) begin
          w_capture   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counter and operand registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_start  <= 1'b0;
      r_mult_a <= '0;
      r_mult_b <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_start <= w_start_nxt;
      if (w_pop) begin
        r_mult_a <= r_mem_a[r_rd_ptr];
        r_mult_b <= r_mem_b[r_rd_ptr];
      end
    end
  end

  // FIFO storage (no reset needed; occupancy is tracked by r_count)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= in_a;
      r_mem_b[r_wr_ptr] <= in_b;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Result register: a capture wins over a simultaneous drain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid   <= 1'b0;
      r_out_product <= '0;
    end else if (w_capture) begin
      r_out_valid   <= 1'b1;
      r_out_product <= mult_product;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign mult_start  = r_start;
  assign mult_a      = r_mult_a;
  assign mult_b      = r_mult_b;
  assign out_valid   = r_out_valid;
  assign out_product = r_out_product;

`ifdef MULT_SEQ_CHECK_EN
  // Busy is expected high for cnt 1..LAT-2 of a run and low everywhere else
  logic w_busy_exp;
  logic r_err;
  assign w_busy_exp = (r_state == S_RUN) && (r_cnt >= CW'(1)) && (r_cnt <= CW'(LAT - 2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_err <= 1'b0;
    else          r_err <= r_err | (mult_busy != w_busy_exp);
  end

  assign err = r_err;
`else
  logic w_unused_busy;
  assign w_unused_busy = mult_busy;
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_mult32x32_seq.sv
// Testbench for mult32x32_seq: a behavioural multiplier answers the start
// pulses, a queue holds expected products, and a monitor checks each accepted result.
module tb_mult32x32_seq;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        mult_start;
  logic [31:0] mult_a;
  logic [31:0] mult_b;
  logic        mult_busy;
  logic [63:0] mult_product;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_product;
  logic        err;

  int          n_checks;
  int          n_fail;
  logic [63:0] sb [$];

  logic [3:0]  m_cnt;
  logic [63:0] m_prod;
  logic        stub_dead;
  logic        stable;
  logic        exp_err;

  mult32x32_seq #(.DEPTH(2), .LAT(9)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .mult_start   (mult_start),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_busy    (mult_busy),
    .mult_product (mult_product),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_product  (out_product),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: busy for 7 cycles after start, product final 8 cycles
  // after start, garbage on the product while running
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt  <= '0;
      m_prod <= '0;
    end else if (mult_start) begin
      m_cnt  <= 4'd1;
      m_prod <= 64'hDEAD_BEEF_DEAD_BEEF;
    end else if (m_cnt != 4'd0) begin
      if (m_cnt == 4'd7) m_prod <= 64'(mult_a) * 64'(mult_b);
      m_cnt <= (m_cnt == 4'd9) ? 4'd0 : m_cnt + 4'd1;
    end
  end

  assign mult_busy    = !stub_dead && (m_cnt >= 4'd1) && (m_cnt <= 4'd7);
  assign mult_product = m_prod;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    sb.push_back(exp);
  endtask

  task automatic wait_sb_empty(input string name, input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      step();
      k++;
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  // Result monitor: every accepted result must match the head of the queue
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", out_product, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("result", out_product, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    stub_dead = 1'b0;
`ifdef MULT_SEQ_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    // Reset values
    repeat (2) @(posedge clk);
    sample();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_mult_start", 64'(mult_start), 64'd0);
    check("rst_mult_a", 64'(mult_a), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_product", out_product, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    step();
    reset_n = 1'b1;
    repeat (2) step();

    // 3 x 5: start in c+2, result in c+12
    push(32'd3, 32'd5, 64'h0000_0000_0000_000F);
    sample();
    check("t1_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    sample();
    check("t1_start_c1", 64'(mult_start), 64'd0);
    step();
    sample();
    check("t1_start_c2", 64'(mult_start), 64'd1);
    check("t1_mult_a", 64'(mult_a), 64'd3);
    check("t1_mult_b", 64'(mult_b), 64'd5);
    step();
    sample();
    check("t1_start_c3", 64'(mult_start), 64'd0);
    repeat (8) step();
    sample();
    check("t1_valid_c11", 64'(out_valid), 64'd0);
    step();
    sample();
    check("t1_valid_c12", 64'(out_valid), 64'd1);
    check("t1_product_c12", out_product, 64'h0000_0000_0000_000F);
    step();
    sample();
    check("t1_valid_c13", 64'(out_valid), 64'd0);

    // Max operands; operands stay stable through the run
    step();
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    step();
    in_valid = 1'b0;
    step();
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (mult_a !== 32'hFFFF_FFFF || mult_b !== 32'hFFFF_FFFF) stable = 1'b0;
      step();
    end
    check("t2_operands_stable", 64'(stable), 64'd1);
    sample();
    check("t2_valid_c12", 64'(out_valid), 64'd1);
    check("t2_product", out_product, 64'hFFFF_FFFE_0000_0001);
    step();

    // Three back-to-back pushes into a 2-deep FIFO
    step();
    push(32'd0, 32'd5, 64'd0);
    step();
    push(32'd1, 32'd1, 64'd1);
    sample();
    check("t3_ready_c1", 64'(in_ready), 64'd1);
    step();
    push(32'd2, 32'd1, 64'd2);
    sample();
    check("t3_ready_c2", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    sample();
    check("t3_full_c3", 64'(in_ready), 64'd0);
    repeat (9) step();
    sample();
    check("t3_full_c12", 64'(in_ready), 64'd0);
    step();
    sample();
    check("t3_ready_c13", 64'(in_ready), 64'd1);
    wait_sb_empty("t3_drain", 100);

    // Back-pressure: first result held, second operation waits in S_HOLD
    out_ready = 1'b0;
    step();
    push(32'd10, 32'd10, 64'd100);
    step();
    push(32'd3, 32'd7, 64'd21);
    step();
    in_valid = 1'b0;
    repeat (10) step();
    sample();
    check("t4_first_valid", 64'(out_valid), 64'd1);
    check("t4_first_product", out_product, 64'd100);
    repeat (10) step();
    sample();
    check("t4_held_c22", out_product, 64'd100);
    step();
    sample();
    check("t4_hold_c23", out_product, 64'd100);
    check("t4_no_restart", 64'(mult_start), 64'd0);
    repeat (2) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    sample();
    check("t4_second_valid", 64'(out_valid), 64'd1);
    check("t4_second_product", out_product, 64'd21);
    step();
    out_ready = 1'b1;
    wait_sb_empty("t4_drain", 20);

    // Reset in the middle of a run discards it
    step();
    in_valid = 1'b1;
    in_a     = 32'd11;
    in_b     = 32'd13;
    step();
    in_valid = 1'b0;
    step();
    sample();
    check("t5_start", 64'(mult_start), 64'd1);
    repeat (4) step();
    reset_n = 1'b0;
    sample();
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_start", 64'(mult_start), 64'd0);
    check("t5_rst_in_ready", 64'(in_ready), 64'd1);
    check("t5_rst_mult_a", 64'(mult_a), 64'd0);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (15) step();
    sample();
    check("t5_no_result", 64'(out_valid), 64'd0);
    step();
    push(32'd7, 32'd6, 64'd42);
    step();
    in_valid = 1'b0;
    wait_sb_empty("t5_drain", 30);

    // Busy stuck low: err sets one cycle after the first mismatch
    sample();
    check("t6_err_before", 64'(err), 64'd0);
    stub_dead = 1'b1;
    step();
    push(32'd4, 32'd5, 64'd20);
    step();
    in_valid = 1'b0;
    step();
    step();
    sample();
    check("t6_err_t0p1", 64'(err), 64'd0);
    step();
    sample();
    check("t6_err_t0p2", 64'(err), 64'(exp_err));
    wait_sb_empty("t6_drain", 30);
    repeat (3) step();
    sample();
    check("t6_err_sticky", 64'(err), 64'(exp_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
